// File: rtl/render_fb_writer.sv
// Pixel-stream responder for the 3D-region frame buffer: windowing, RGB444 packing,
// linear addressing with the cylinder-region x shift, and a small write FIFO with backpressure.
module render_fb_writer #(
    parameter int START_X       = 390,
    parameter int START_Y       = 390,
    parameter int END_X         = 634,
    parameter int END_Y         = 765,
    parameter int REGION_DIVIDE = 530,
    parameter int CYL_X_SHIFT   = 2,
    parameter int FIFO_DEPTH    = 4,
    parameter int ADDR_W        = 17
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [23:0]       pixel_axis_tdata,
    input  logic              pixel_axis_tvalid,
    output logic              pixel_axis_tready,
    input  logic [10:0]       hcount_in,
    input  logic [9:0]        vcount_in,
    input  logic              fb_stall_in,
    output logic              fb_we_out,
    output logic [ADDR_W-1:0] fb_addr_out,
    output logic [11:0]       fb_data_out,
    output logic              frame_done_out,
    output logic [7:0]        frame_count_out,
    output logic [7:0]        drop_count_out,
    output logic [2:0]        fifo_level_out
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int W     = END_X - START_X;
    localparam int H     = END_Y - START_Y;

    localparam logic signed [11:0] SX_S  = 12'(START_X);
    localparam logic signed [11:0] SY_S  = 12'(START_Y);
    localparam logic signed [11:0] W_S   = 12'(W);
    localparam logic signed [11:0] H_S   = 12'(H);
    localparam logic signed [11:0] CYL_S = 12'(CYL_X_SHIFT);
    localparam logic [9:0]         VDIV  = 10'(REGION_DIVIDE);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [11:0]       data;
        logic              last;
    } entry_t;

    function automatic logic [11:0] pack444(input logic [23:0] rgb);
        return {rgb[23:20], rgb[15:12], rgb[7:4]};
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Coordinate mapping on the incoming beat
    logic signed [11:0] shift_s, x_s, y_s;
    logic               in_win_c, last_c;
    logic [ADDR_W-1:0]  addr_c;

    always_comb begin
        shift_s  = (vcount_in < VDIV) ? CYL_S : 12'sd0;
        x_s      = $signed({1'b0, hcount_in}) - SX_S - shift_s;
        y_s      = $signed({2'b00, vcount_in}) - SY_S;
        in_win_c = (x_s >= 12'sd0) && (x_s < W_S) && (y_s >= 12'sd0) && (y_s < H_S);
        last_c   = (x_s == W_S - 12'sd1) && (y_s == H_S - 12'sd1);
        addr_c   = ADDR_W'($unsigned(y_s)) * ADDR_W'(W) + ADDR_W'($unsigned(x_s));
    end

    logic                 rdy_en_q, rdy_en_d;
    logic                 s1_vld_q, s1_vld_d;
    logic                 s1_win_q, s1_win_d;
    entry_t               s1_ent_q, s1_ent_d;
    entry_t               mem_q [FIFO_DEPTH];
    entry_t               rd_ent;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 we_q, we_d, done_q, done_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [11:0]          data_q, data_d;
    logic [7:0]           fc_q, fc_d, drop_q, drop_d;
    logic                 accept, push, pop;

    // Ready looks only at registered occupancy so it never depends on tvalid
    assign pixel_axis_tready = rdy_en_q &&
                               ((level_q + LVL_W'(s1_vld_q)) < LVL_W'(FIFO_DEPTH));
    assign accept = pixel_axis_tvalid && pixel_axis_tready;
    assign push   = s1_vld_q && s1_win_q;
    assign pop    = (level_q != '0) && !fb_stall_in;
    assign rd_ent = mem_q[rd_ptr_q];

    always_comb begin
        rdy_en_d = 1'b1;
        s1_vld_d = accept;
        s1_win_d = s1_win_q;
        s1_ent_d = s1_ent_q;
        if (accept) begin
            s1_win_d = in_win_c;
            s1_ent_d = '{addr: addr_c, data: pack444(pixel_axis_tdata), last: last_c};
        end
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        drop_d = (s1_vld_q && !s1_win_q) ? sat_inc8(drop_q) : drop_q;
        we_d   = pop;
        addr_d = pop ? rd_ent.addr : addr_q;
        data_d = pop ? rd_ent.data : data_q;
        done_d = pop && rd_ent.last;
        fc_d   = done_d ? fc_q + 8'd1 : fc_q;
    end

    // Stage 1 register and FIFO/output control state
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rdy_en_q <= 1'b0;
            s1_vld_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            fc_q     <= '0;
            drop_q   <= '0;
        end else begin
            rdy_en_q <= rdy_en_d;
            s1_vld_q <= s1_vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            done_q   <= done_d;
            fc_q     <= fc_d;
            drop_q   <= drop_d;
        end
    end

    // Datapath storage carries no reset; validity comes from s1_vld_q and the pointers
    always_ff @(posedge clk_in) begin
        s1_win_q <= s1_win_d;
        s1_ent_q <= s1_ent_d;
        if (push) mem_q[wr_ptr_q] <= s1_ent_q;
    end

    assign fb_we_out       = we_q;
    assign fb_addr_out     = addr_q;
    assign fb_data_out     = data_q;
    assign frame_done_out  = done_q;
    assign frame_count_out = fc_q;
    assign drop_count_out  = drop_q;
    assign fifo_level_out  = 3'(level_q);

endmodule

// File: tb/tb_render_fb_writer.sv
// Directed bench for render_fb_writer: vector table for addressing/windowing plus
// hand-written stall, wrap, reset and saturation sequences.
module tb_render_fb_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] tdata;
    logic        tvalid;
    logic        tready;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        stall;
    logic        we;
    logic [16:0] addr;
    logic [11:0] data;
    logic        done;
    logic [7:0]  fcount;
    logic [7:0]  dcount;
    logic [2:0]  level;

    always #5 clk = ~clk;

    render_fb_writer dut (
        .clk_in            (clk),
        .rst_in            (rst),
        .pixel_axis_tdata  (tdata),
        .pixel_axis_tvalid (tvalid),
        .pixel_axis_tready (tready),
        .hcount_in         (hcount),
        .vcount_in         (vcount),
        .fb_stall_in       (stall),
        .fb_we_out         (we),
        .fb_addr_out       (addr),
        .fb_data_out       (data),
        .frame_done_out    (done),
        .frame_count_out   (fcount),
        .drop_count_out    (dcount),
        .fifo_level_out    (level)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    typedef struct {
        int          hc;
        int          vc;
        logic [23:0] d;
        bit          exp_we;
        int          exp_addr;
        int          exp_data;
        bit          exp_done;
    } vec_t;

    vec_t vecs[10];

    task automatic send_beat(input int hc, input int vc, input logic [23:0] d);
        @(negedge clk);
        hcount = 11'(hc);
        vcount = 10'(vc);
        tdata  = d;
        tvalid = 1'b1;
        @(posedge clk);
        #1 tvalid = 1'b0;
    endtask

    initial begin
        int exp_drop, exp_fc, idx, nw, pulses;
        bit rdy;
        int waddr[$];
        int wcyc[$];

        rst = 1'b1; tvalid = 1'b0; stall = 1'b0;
        tdata = '0; hcount = '0; vcount = '0;

        vecs[0] = '{392, 390, 24'hABCDEF, 1'b1, 0,     'hACE, 1'b0};
        vecs[1] = '{390, 600, 24'h123456, 1'b1, 51240, 'h135, 1'b0};
        vecs[2] = '{390, 390, 24'hABCDEF, 1'b0, 0,     0,     1'b0};
        vecs[3] = '{633, 764, 24'hFFFFFF, 1'b1, 91499, 'hFFF, 1'b1};
        vecs[4] = '{635, 529, 24'h808080, 1'b1, 34159, 'h888, 1'b0};
        vecs[5] = '{634, 600, 24'h111111, 1'b0, 0,     0,     1'b0};
        vecs[6] = '{391, 389, 24'h111111, 1'b0, 0,     0,     1'b0};
        vecs[7] = '{500, 765, 24'h111111, 1'b0, 0,     0,     1'b0};
        vecs[8] = '{391, 530, 24'h0F1E2D, 1'b1, 34161, 'h012, 1'b0};
        vecs[9] = '{392, 529, 24'h00F000, 1'b1, 33916, 'h0F0, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_tready", tready, 0);
        check("rst_we", we, 0);
        check("rst_level", level, 0);
        check("rst_fcount", fcount, 0);
        check("rst_dcount", dcount, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 check("rel_tready", tready, 1);

        // Vector table: one beat each, write expected two edges after accept
        exp_drop = 0;
        exp_fc   = 0;
        foreach (vecs[i]) begin
            send_beat(vecs[i].hc, vecs[i].vc, vecs[i].d);
            @(posedge clk);
            @(posedge clk);
            #1;
            if (!vecs[i].exp_we) exp_drop++;
            if (vecs[i].exp_done) exp_fc++;
            check($sformatf("v%0d_we", i), we, int'(vecs[i].exp_we));
            if (vecs[i].exp_we) begin
                check($sformatf("v%0d_addr", i), addr, vecs[i].exp_addr);
                check($sformatf("v%0d_data", i), data, vecs[i].exp_data);
            end
            check($sformatf("v%0d_done", i), done, int'(vecs[i].exp_done));
            check($sformatf("v%0d_drop", i), dcount, exp_drop);
            check($sformatf("v%0d_fcount", i), fcount, exp_fc);
        end

        // Stall: 8 beats offered continuously, only 4 fit
        stall = 1'b1;
        idx = 0; nw = 0;
        for (int cyc = 0; cyc < 80 && (idx < 8 || nw < 8); cyc++) begin
            @(negedge clk);
            if (cyc == 12) begin
                check("stall_accepted", idx, 4);
                check("stall_tready", tready, 0);
                check("stall_level", level, 4);
                stall = 1'b0;
            end
            if (idx < 8) begin
                hcount = 11'(392 + idx);
                vcount = 10'd390;
                tdata  = 24'(idx * 24'h111111);
                tvalid = 1'b1;
            end else begin
                tvalid = 1'b0;
            end
            rdy = tready;
            @(posedge clk);
            #1;
            if (rdy && tvalid) idx++;
            if (we) begin
                nw++;
                waddr.push_back(int'(addr));
                wcyc.push_back(cyc);
            end
        end
        tvalid = 1'b0;
        check("stall_total_writes", nw, 8);
        for (int k = 0; k < 8; k++)
            check($sformatf("stall_order%0d", k), (k < waddr.size()) ? waddr[k] : -1, k);
        check("stall_consecutive", (wcyc.size() >= 4) ? wcyc[3] - wcyc[0] : -1, 3);

        // Frame counter wraps after 256 completed frames
        pulses = 0;
        for (int k = 0; k < 255; k++) begin
            send_beat(633, 764, 24'h00FF00);
            @(posedge clk);
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("wrap_pulses", pulses, 255);
        check("wrap_fcount", fcount, 0);

        // Reset with entries queued under stall
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            hcount = 11'(400 + k);
            vcount = 10'd400;
            tdata  = 24'h445566;
            tvalid = 1'b1;
            @(posedge clk);
        end
        #1 tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("prerst_level", level, 3);
        #2 rst = 1'b1;
        #1;
        check("midrst_we", we, 0);
        check("midrst_level", level, 0);
        check("midrst_tready", tready, 0);
        check("midrst_dcount", dcount, 0);
        @(negedge clk);
        rst   = 1'b0;
        stall = 1'b0;
        @(posedge clk);
        #1 check("postrst_tready", tready, 1);
        nw = 0;
        repeat (6) begin
            @(posedge clk);
            #1 if (we) nw++;
        end
        check("postrst_writes", nw, 0);
        check("postrst_fcount", fcount, 0);

        // Drop counter saturation with a continuous off-window stream
        @(negedge clk);
        hcount = 11'd100;
        vcount = 10'd400;
        tdata  = 24'h123123;
        tvalid = 1'b1;
        nw = 0;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk);
            #1;
            if (we) nw++;
            if (k == 100) check("drop_mid", dcount, 99);
        end
        tvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("drop_sat", dcount, 255);
        check("drop_writes", nw, 0);
        check("drop_level", level, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
